// File: rtl/id_ex_if.sv
// id_ex_if: decode-to-execute bundle; master drives the ID, WB and control inputs, slave is the pipeline register
interface id_ex_if #(parameter int CTRL_W = 12);
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2;
  logic [31:0]       id_rs1_data, id_rs2_data, id_imm;
  logic              id_reg_write, id_mem_read;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              flush, mem_stall;
  logic              id_stall;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [31:0]       ex_rs1_data, ex_rs2_data, ex_imm;
  logic              ex_reg_write, ex_mem_read;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       bubble_count;
  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_reg_write, id_mem_read, id_ctrl,
           wb_reg_write, wb_rd, wb_data, flush, mem_stall,
    input  id_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_reg_write, ex_mem_read, ex_ctrl, bubble_count
  );
  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_reg_write, id_mem_read, id_ctrl,
           wb_reg_write, wb_rd, wb_data, flush, mem_stall,
    output id_stall, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_reg_write, ex_mem_read, ex_ctrl, bubble_count
  );
endinterface

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use bubble, flush, stall hold, WB bypass and bubble counter (ports: clk, rst, b = id_ex_if.slave)
module id_ex_register #(parameter int CTRL_W = 12) (
  input logic  clk,
  input logic  rst,
  id_ex_if.slave b
);
  logic              r_valid, r_reg_write, r_mem_read;
  logic [31:0]       r_pc, r_rs1_data, r_rs2_data, r_imm, r_cnt;
  logic [4:0]        r_rs1, r_rs2, r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic w_lu, w_hold1, w_hold2, w_load1, w_load2, w_wb;
  assign w_lu = r_valid & r_mem_read & (r_rd != 5'd0) & b.id_valid &
                ((b.id_uses_rs1 & (r_rd == b.id_rs1)) | (b.id_uses_rs2 & (r_rd == b.id_rs2)));
  assign b.id_stall = b.mem_stall | (w_lu & ~b.flush);
  // x0 is excluded once here so neither bypass path can ever target it
  assign w_wb    = b.wb_reg_write & (b.wb_rd != 5'd0);
  assign w_hold1 = w_wb & (b.wb_rd == r_rs1);
  assign w_hold2 = w_wb & (b.wb_rd == r_rs2);
  assign w_load1 = w_wb & (b.wb_rd == b.id_rs1);
  assign w_load2 = w_wb & (b.wb_rd == b.id_rs2);
  always_ff @(posedge clk)
    if (rst || b.flush) begin
      r_valid <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read <= 1'b0;
      r_pc <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm <= '0;
      r_ctrl <= '0;
    end else if (b.mem_stall) begin
      // a held instruction must still see results retiring while it waits
      if (w_hold1) r_rs1_data <= b.wb_data;
      if (w_hold2) r_rs2_data <= b.wb_data;
    end else if (w_lu) begin
      r_valid <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read <= 1'b0;
    end else begin
      r_valid <= b.id_valid;
      r_reg_write <= b.id_valid & b.id_reg_write;
      r_mem_read <= b.id_valid & b.id_mem_read;
      r_pc <= b.id_pc;
      r_rs1 <= b.id_rs1;
      r_rs2 <= b.id_rs2;
      r_rd <= b.id_rd;
      r_rs1_data <= w_load1 ? b.wb_data : b.id_rs1_data;
      r_rs2_data <= w_load2 ? b.wb_data : b.id_rs2_data;
      r_imm <= b.id_imm;
      r_ctrl <= b.id_ctrl;
    end
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (w_lu && !b.flush && !b.mem_stall && !(&r_cnt)) r_cnt <= r_cnt + 32'd1;
  assign b.ex_valid = r_valid;
  assign b.ex_pc = r_pc;
  assign b.ex_rs1 = r_rs1;
  assign b.ex_rs2 = r_rs2;
  assign b.ex_rd = r_rd;
  assign b.ex_rs1_data = r_rs1_data;
  assign b.ex_rs2_data = r_rs2_data;
  assign b.ex_imm = r_imm;
  assign b.ex_reg_write = r_reg_write;
  assign b.ex_mem_read = r_mem_read;
  assign b.ex_ctrl = r_ctrl;
  assign b.bubble_count = r_cnt;
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: vector table, directed corner sequences and random traffic against a behavioural model
module tb_id_ex_register;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  id_ex_if #(.CTRL_W(12)) bus();
  id_ex_register #(.CTRL_W(12)) dut(.clk(clk), .rst(rst), .b(bus));
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        rw, mr;
    logic [11:0] ctrl;
    logic [31:0] cnt;
  } st_t;
  typedef struct {
    logic        v, u1, u2, rw, mr, wrw;
    logic [4:0]  rs1, rs2, rd, wrd;
    logic [31:0] d1, d2, wd;
    logic        e_stall, e_valid, e_rw, e_mr;
    logic [31:0] e_d1, e_d2;
  } vec_t;
  st_t m;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  function automatic bit reads(logic [4:0] r);
    return (bus.id_uses_rs1 && bus.id_rs1 == r) || (bus.id_uses_rs2 && bus.id_rs2 == r);
  endfunction
  function automatic bit hazard(st_t s);
    return s.valid && s.mr && s.rd != 0 && bus.id_valid && reads(s.rd);
  endfunction
  function automatic logic [31:0] fwd(logic [4:0] idx, logic [31:0] d);
    return (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == idx) ? bus.wb_data : d;
  endfunction
  function automatic st_t next_st(st_t s, logic r);
    st_t n = s;
    if (r) n = '0;
    else if (bus.flush) begin
      n = '0;
      n.cnt = s.cnt;
    end else if (bus.mem_stall) begin
      n.d1 = fwd(s.rs1, s.d1);
      n.d2 = fwd(s.rs2, s.d2);
    end else if (hazard(s)) begin
      n.valid = 0;
      n.rw = 0;
      n.mr = 0;
      n.cnt = (s.cnt == 32'hFFFF_FFFF) ? s.cnt : s.cnt + 1;
    end else begin
      n.valid = bus.id_valid;
      n.pc = bus.id_pc;
      n.rs1 = bus.id_rs1;
      n.rs2 = bus.id_rs2;
      n.rd = bus.id_rd;
      n.d1 = fwd(bus.id_rs1, bus.id_rs1_data);
      n.d2 = fwd(bus.id_rs2, bus.id_rs2_data);
      n.imm = bus.id_imm;
      n.ctrl = bus.id_ctrl;
      n.rw = bus.id_valid && bus.id_reg_write;
      n.mr = bus.id_valid && bus.id_mem_read;
    end
    return n;
  endfunction
  task automatic cmp_all();
    chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    chk("ex_pc", bus.ex_pc, m.pc);
    chk("ex_rs1", 32'(bus.ex_rs1), 32'(m.rs1));
    chk("ex_rs2", 32'(bus.ex_rs2), 32'(m.rs2));
    chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
    chk("ex_rs1_data", bus.ex_rs1_data, m.d1);
    chk("ex_rs2_data", bus.ex_rs2_data, m.d2);
    chk("ex_imm", bus.ex_imm, m.imm);
    chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
    chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
    chk("ex_ctrl", 32'(bus.ex_ctrl), 32'(m.ctrl));
    chk("bubble_count", bus.bubble_count, m.cnt);
    if (!bus.ex_valid) chk("bubble_inert", 32'({bus.ex_reg_write, bus.ex_mem_read}), 32'd0);
  endtask
  task automatic step(logic r);
    st_t n;
    rst = r;
    #1;
    chk("id_stall", 32'(bus.id_stall), 32'(bus.mem_stall || (hazard(m) && !bus.flush)));
    n = next_st(m, r);
    @(posedge clk);
    #1;
    m = n;
    cmp_all();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic set_id(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic u1, logic u2,
                        logic [31:0] d1, logic [31:0] d2, logic rw, logic mr);
    bus.id_valid = v;
    bus.id_rs1 = rs1;
    bus.id_rs2 = rs2;
    bus.id_rd = rd;
    bus.id_uses_rs1 = u1;
    bus.id_uses_rs2 = u2;
    bus.id_rs1_data = d1;
    bus.id_rs2_data = d2;
    bus.id_reg_write = rw;
    bus.id_mem_read = mr;
    bus.id_pc = $urandom;
    bus.id_imm = $urandom;
    bus.id_ctrl = 12'($urandom);
  endtask
  task automatic set_wb(logic rw, logic [4:0] rd, logic [31:0] d);
    bus.wb_reg_write = rw;
    bus.wb_rd = rd;
    bus.wb_data = d;
  endtask
  vec_t tbl[8];
  initial begin
    tbl[0] = '{1,1,1,1,0,1, 3,4,8,3, 32'h0,32'h44,32'hDEADBEEF, 0,1,1,0, 32'hDEADBEEF,32'h44};
    tbl[1] = '{1,1,1,1,1,1, 0,0,5,0, 32'h1111,32'h2222,32'hCAFE, 0,1,1,1, 32'h1111,32'h2222};
    tbl[2] = '{1,1,0,1,1,0, 6,5,0,0, 32'h33,32'h44,32'h0, 0,1,1,1, 32'h33,32'h44};
    tbl[3] = '{1,1,1,1,0,0, 0,0,7,0, 32'h55,32'h66,32'h0, 0,1,1,0, 32'h55,32'h66};
    tbl[4] = '{0,1,1,1,1,0, 7,7,2,0, 32'h77,32'h88,32'h0, 0,0,0,0, 32'h77,32'h88};
    tbl[5] = '{1,1,1,1,1,0, 1,2,5,0, 32'h9,32'hA,32'h0, 0,1,1,1, 32'h9,32'hA};
    tbl[6] = '{1,0,1,1,0,0, 1,5,6,0, 32'hB,32'hC,32'h0, 1,0,0,0, 32'h9,32'hA};
    tbl[7] = '{1,0,1,1,0,0, 1,5,6,0, 32'hB,32'hC,32'h0, 0,1,1,0, 32'hB,32'hC};
    bus.flush = 0;
    bus.mem_stall = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    m = '0;
    @(negedge clk);
    step(1);
    step(1);
    cmp_all();
    foreach (tbl[i]) begin
      set_id(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2,
             tbl[i].d1, tbl[i].d2, tbl[i].rw, tbl[i].mr);
      set_wb(tbl[i].wrw, tbl[i].wrd, tbl[i].wd);
      #1;
      chk($sformatf("row%0d stall", i), 32'(bus.id_stall), 32'(tbl[i].e_stall));
      step(0);
      chk($sformatf("row%0d valid", i), 32'(bus.ex_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d rw", i), 32'(bus.ex_reg_write), 32'(tbl[i].e_rw));
      chk($sformatf("row%0d mr", i), 32'(bus.ex_mem_read), 32'(tbl[i].e_mr));
      chk($sformatf("row%0d d1", i), bus.ex_rs1_data, tbl[i].e_d1);
      chk($sformatf("row%0d d2", i), bus.ex_rs2_data, tbl[i].e_d2);
    end
    chk("table bubbles", bus.bubble_count, 32'd1);
    set_wb(0, 0, 0);
    set_id(1, 1, 2, 5, 1, 1, 32'h10, 32'h20, 1, 1);
    step(0);
    set_id(1, 5, 7, 6, 1, 1, 32'h50, 32'h70, 1, 0);
    #1;
    chk("lu rs1 stall", 32'(bus.id_stall), 32'd1);
    step(0);
    chk("lu rs1 bubble", 32'(bus.ex_valid), 32'd0);
    chk("lu rs1 count", bus.bubble_count, 32'd2);
    step(0);
    chk("lu rs1 resume rs1", 32'(bus.ex_rs1), 32'd5);
    chk("lu rs1 resume rd", 32'(bus.ex_rd), 32'd6);
    set_id(1, 1, 2, 5, 1, 1, 32'h10, 32'h20, 1, 1);
    step(0);
    set_id(1, 5, 7, 6, 1, 1, 32'h50, 32'h70, 1, 0);
    bus.flush = 1;
    bus.mem_stall = 1;
    #1;
    chk("flush stall", 32'(bus.id_stall), 32'd1);
    step(0);
    chk("flush valid", 32'(bus.ex_valid), 32'd0);
    chk("flush count", bus.bubble_count, 32'd2);
    bus.flush = 0;
    bus.mem_stall = 0;
    set_id(1, 4, 9, 3, 1, 1, 32'h40, 32'h90, 1, 0);
    step(0);
    bus.mem_stall = 1;
    set_id(1, 1, 2, 8, 1, 1, 32'h111, 32'h222, 1, 1);
    step(0);
    set_wb(1, 9, 32'h9999_0009);
    step(0);
    chk("hold rs2 bypass", bus.ex_rs2_data, 32'h9999_0009);
    chk("hold rs1 kept", bus.ex_rs1_data, 32'h40);
    set_wb(0, 0, 0);
    step(0);
    chk("hold rd kept", 32'(bus.ex_rd), 32'd3);
    bus.mem_stall = 0;
    step(0);
    chk("stall release load", 32'(bus.ex_rd), 32'd8);
    @(negedge clk);
    force dut.r_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_cnt;
    m.cnt = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      set_id(1, 1, 2, 5, 1, 1, 32'h10, 32'h20, 1, 1);
      step(0);
      set_id(1, 5, 5, 6, 1, 1, 32'h50, 32'h70, 1, 0);
      step(0);
    end
    chk("saturate", bus.bubble_count, 32'hFFFF_FFFF);
    bus.mem_stall = 1;
    set_wb(1, 5, 32'h1234);
    step(1);
    chk("rst stall valid", 32'(bus.ex_valid), 32'd0);
    chk("rst stall count", bus.bubble_count, 32'd0);
    chk("rst stall d2", bus.ex_rs2_data, 32'd0);
    for (int k = 0; k < 400; k++) begin
      bus.mem_stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom, $urandom,
             1'($urandom), 1'($urandom));
      set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      step($urandom_range(0, 49) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
